// File: rtl/axil_manager.sv
// Single-outstanding AXI4-Lite manager: turns a valid/ready command stream into
// one AW/W/B or AR/R transaction at a time and returns the result on a response stream.
module axil_manager #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 4,
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       axi_aclk_in,
    input  logic                       axi_areset_in,

    input  logic                       cmd_valid_in,
    output logic                       cmd_ready_out,
    input  logic                       cmd_write_in,
    input  logic [ADDRESS_WIDTH-1:0]   cmd_addr_in,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata_in,
    input  logic [DATA_WIDTH/8-1:0]    cmd_wstrb_in,

    output logic                       rsp_valid_out,
    input  logic                       rsp_ready_in,
    output logic                       rsp_write_out,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_out,
    output logic [1:0]                 rsp_resp_out,
    output logic [ERR_COUNT_WIDTH-1:0] err_count_out,

    output logic [ADDRESS_WIDTH-1:0]   axi_awaddr_out,
    output logic [2:0]                 axi_awprot_out,
    output logic                       axi_awvalid_out,
    input  logic                       axi_awready_in,

    output logic [DATA_WIDTH-1:0]      axi_wdata_out,
    output logic [DATA_WIDTH/8-1:0]    axi_wstrb_out,
    output logic                       axi_wvalid_out,
    input  logic                       axi_wready_in,

    input  logic [1:0]                 axi_bresp_in,
    input  logic                       axi_bvalid_in,
    output logic                       axi_bready_out,

    output logic [ADDRESS_WIDTH-1:0]   axi_araddr_out,
    output logic [2:0]                 axi_arprot_out,
    output logic                       axi_arvalid_out,
    input  logic                       axi_arready_in,

    input  logic [DATA_WIDTH-1:0]      axi_rdata_in,
    input  logic [1:0]                 axi_rresp_in,
    input  logic                       axi_rvalid_in,
    output logic                       axi_rready_out
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state, state_next;

    logic                       aw_done, w_done;
    logic [ADDRESS_WIDTH-1:0]   awaddr, araddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [STRB_WIDTH-1:0]      wstrb;
    logic                       rsp_write;
    logic [DATA_WIDTH-1:0]      rsp_rdata;
    logic [1:0]                 rsp_resp;
    logic [ERR_COUNT_WIDTH-1:0] err_count;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    logic capture;
    logic [1:0] captured_resp;

    assign cmd_ready_out = (state == IDLE) && !axi_areset_in;

    assign cmd_hs = cmd_valid_in && cmd_ready_out;
    assign aw_hs  = axi_awvalid_out && axi_awready_in;
    assign w_hs   = axi_wvalid_out && axi_wready_in;
    assign b_hs   = axi_bready_out && axi_bvalid_in;
    assign ar_hs  = axi_arvalid_out && axi_arready_in;
    assign r_hs   = axi_rready_out && axi_rvalid_in;
    assign rsp_hs = rsp_valid_out && rsp_ready_in;

    assign capture       = b_hs || r_hs;
    assign captured_resp = b_hs ? axi_bresp_in : axi_rresp_in;

    // State register
    always_ff @(posedge axi_aclk_in) begin
        if (axi_areset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_hs) state_next = cmd_write_in ? WR_REQ : RD_REQ;
            // AW and W may finish on different edges or the same one
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            WR_RESP: if (b_hs) state_next = RSP;
            RD_REQ:  if (ar_hs) state_next = RD_RESP;
            RD_RESP: if (r_hs) state_next = RSP;
            RSP:     if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: valids/readies decode from registered state and done flags only
    always_comb begin
        axi_awvalid_out = (state == WR_REQ) && !aw_done;
        axi_wvalid_out  = (state == WR_REQ) && !w_done;
        axi_bready_out  = (state == WR_RESP);
        axi_arvalid_out = (state == RD_REQ);
        axi_rready_out  = (state == RD_RESP);
        rsp_valid_out   = (state == RSP);
    end

    // Datapath: payload latches, per-channel done flags, response capture, error count
    always_ff @(posedge axi_aclk_in) begin
        if (axi_areset_in) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            err_count <= '0;
        end else begin
            if (cmd_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (cmd_write_in) begin
                    awaddr <= cmd_addr_in;
                    wdata  <= cmd_wdata_in;
                    wstrb  <= cmd_wstrb_in;
                end else begin
                    araddr <= cmd_addr_in;
                end
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;

            if (b_hs) begin
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= axi_bresp_in;
            end else if (r_hs) begin
                rsp_write <= 1'b0;
                rsp_rdata <= axi_rdata_in;
                rsp_resp  <= axi_rresp_in;
            end

            if (capture && (captured_resp != 2'b00) &&
                (err_count != {ERR_COUNT_WIDTH{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign axi_awaddr_out = awaddr;
    assign axi_awprot_out = 3'b000;
    assign axi_wdata_out  = wdata;
    assign axi_wstrb_out  = wstrb;
    assign axi_araddr_out = araddr;
    assign axi_arprot_out = 3'b000;

    assign rsp_write_out  = rsp_write;
    assign rsp_rdata_out  = rsp_rdata;
    assign rsp_resp_out   = rsp_resp;
    assign err_count_out  = err_count;

endmodule

// File: tb/tb_axil_manager.sv
// Directed bench for axil_manager: the bench plays the AXI-Lite subordinate with
// scripted ready latencies and response codes, and checks hand-computed results.
module tb_axil_manager;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    // Second instance with a 2-bit error counter, driven by the same inputs
    logic        cmd_ready2, rsp_valid2, rsp_write2;
    logic [31:0] rsp_rdata2, wdata2;
    logic [1:0]  rsp_resp2, err_count2;
    logic [3:0]  awaddr2, araddr2, wstrb2;
    logic [2:0]  awprot2, arprot2;
    logic        awvalid2, wvalid2, bready2, arvalid2, rready2;

    axil_manager #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .ERR_COUNT_WIDTH(16)) dut (
        .axi_aclk_in(clk), .axi_areset_in(rst),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_write_in(cmd_write),
        .cmd_addr_in(cmd_addr), .cmd_wdata_in(cmd_wdata), .cmd_wstrb_in(cmd_wstrb),
        .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_write_out(rsp_write),
        .rsp_rdata_out(rsp_rdata), .rsp_resp_out(rsp_resp), .err_count_out(err_count),
        .axi_awaddr_out(awaddr), .axi_awprot_out(awprot), .axi_awvalid_out(awvalid), .axi_awready_in(awready),
        .axi_wdata_out(wdata), .axi_wstrb_out(wstrb), .axi_wvalid_out(wvalid), .axi_wready_in(wready),
        .axi_bresp_in(bresp), .axi_bvalid_in(bvalid), .axi_bready_out(bready),
        .axi_araddr_out(araddr), .axi_arprot_out(arprot), .axi_arvalid_out(arvalid), .axi_arready_in(arready),
        .axi_rdata_in(rdata), .axi_rresp_in(rresp), .axi_rvalid_in(rvalid), .axi_rready_out(rready)
    );

    axil_manager #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .ERR_COUNT_WIDTH(2)) dut2 (
        .axi_aclk_in(clk), .axi_areset_in(rst),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready2), .cmd_write_in(cmd_write),
        .cmd_addr_in(cmd_addr), .cmd_wdata_in(cmd_wdata), .cmd_wstrb_in(cmd_wstrb),
        .rsp_valid_out(rsp_valid2), .rsp_ready_in(rsp_ready), .rsp_write_out(rsp_write2),
        .rsp_rdata_out(rsp_rdata2), .rsp_resp_out(rsp_resp2), .err_count_out(err_count2),
        .axi_awaddr_out(awaddr2), .axi_awprot_out(awprot2), .axi_awvalid_out(awvalid2), .axi_awready_in(awready),
        .axi_wdata_out(wdata2), .axi_wstrb_out(wstrb2), .axi_wvalid_out(wvalid2), .axi_wready_in(wready),
        .axi_bresp_in(bresp), .axi_bvalid_in(bvalid), .axi_bready_out(bready2),
        .axi_araddr_out(araddr2), .axi_arprot_out(arprot2), .axi_arvalid_out(arvalid2), .axi_arready_in(arready),
        .axi_rdata_in(rdata), .axi_rresp_in(rresp), .axi_rvalid_in(rvalid), .axi_rready_out(rready2)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [4];

    // Observations of the last transaction run through xact
    logic        obs_to, obs_pre, obs_reraise, obs_busy, obs_overlap, obs_unstable, obs_b_early, obs_ready_after;
    int          obs_aw_first, obs_w_first, obs_aw_fall, obs_w_fall, obs_ar_first, obs_bready_k;
    logic [3:0]  obs_awaddr, obs_araddr, obs_wstrb;
    logic [31:0] obs_wdata;
    logic [2:0]  obs_prot;
    logic        obs_rsp_write;
    logic [31:0] obs_rsp_rdata;
    logic [1:0]  obs_rsp_resp;

    // Issue one command and act as the subordinate until the response handshake.
    // lat_a: cycle (from first valid-visible cycle = 1) at which awready/arready rise;
    // lat_w: same for wready. Returns on the negedge after the rsp handshake.
    task automatic xact(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lat_a, input int lat_w, input logic [1:0] resp, input int hold,
                        input logic keep);
        int k, hcnt, aws, ws;
        logic done;
        logic [31:0] ref_d;
        logic [1:0]  ref_r;
        logic        ref_w;
        obs_to = 0; obs_pre = 0; obs_reraise = 0; obs_busy = 0; obs_overlap = 0; obs_unstable = 0;
        obs_b_early = 0; obs_aw_first = -1; obs_w_first = -1; obs_aw_fall = -1; obs_w_fall = -1;
        obs_ar_first = -1; obs_bready_k = -1; obs_prot = 0;
        ref_d = 0; ref_r = 0; ref_w = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        if (!cmd_ready) begin obs_to = 1; cmd_valid = 1'b0; return; end
        obs_pre = awvalid | wvalid | arvalid;
        @(negedge clk);
        cmd_valid = keep;
        k = 1; aws = 0; ws = 0; hcnt = 0; done = 0;
        while (!done && k < 100) begin
            if (cmd_ready) obs_busy = 1;
            if (wr ? arvalid : (awvalid | wvalid)) obs_overlap = 1;
            if (awvalid) begin
                if (aws == 0) begin obs_aw_first = k; obs_awaddr = awaddr; obs_prot |= awprot; aws = 1; end
                else if (aws == 2) obs_reraise = 1;
            end else if (aws == 1) begin obs_aw_fall = k; aws = 2; end
            if (wvalid) begin
                if (ws == 0) begin obs_w_first = k; obs_wdata = wdata; obs_wstrb = wstrb; ws = 1; end
                else if (ws == 2) obs_reraise = 1;
            end else if (ws == 1) begin obs_w_fall = k; ws = 2; end
            if (arvalid && obs_ar_first < 0) begin obs_ar_first = k; obs_araddr = araddr; obs_prot |= arprot; end
            if (bready && obs_bready_k < 0) obs_bready_k = k;
            if (bready && (awvalid || wvalid)) obs_b_early = 1;
            awready = (k >= lat_a); wready = (k >= lat_w); arready = (k >= lat_a);
            bvalid = bready; bresp = bready ? resp : 2'b00;
            rvalid = rready; rdata = rready ? mem[a[3:2]] : 32'h0; rresp = rready ? resp : 2'b00;
            if (bready) for (int i = 0; i < 4; i++) if (s[i]) mem[a[3:2]][8*i +: 8] = d[8*i +: 8];
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (hcnt == 0) begin ref_d = rsp_rdata; ref_r = rsp_resp; ref_w = rsp_write; end
                else if (rsp_rdata !== ref_d || rsp_resp !== ref_r || rsp_write !== ref_w) obs_unstable = 1;
                if (hcnt < hold) hcnt++;
                else begin
                    rsp_ready = 1'b1; done = 1;
                    obs_rsp_write = rsp_write; obs_rsp_rdata = rsp_rdata; obs_rsp_resp = rsp_resp;
                end
            end
            @(negedge clk); k++;
        end
        rsp_ready = 0; awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0; rresp = 0;
        obs_ready_after = cmd_ready;
        if (!done) obs_to = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin failures++;
            $display("FAIL reset_valids got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
        checks++; if ({awvalid2, wvalid2, arvalid2, bready2, rready2, rsp_valid2, cmd_ready2} !== 7'b0) begin failures++;
            $display("FAIL reset_valids_w2 got=%b want=0", {awvalid2, wvalid2, arvalid2, bready2, rready2, rsp_valid2, cmd_ready2}); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d want=0", err_count); end
        checks++; if ({rsp_rdata, rsp_resp, rsp_write} !== 35'd0) begin failures++;
            $display("FAIL reset_rsp_data got=%h/%h/%b want=0", rsp_rdata, rsp_resp, rsp_write); end
        checks++; if ({awaddr, wdata, wstrb, araddr} !== 44'd0) begin failures++;
            $display("FAIL reset_payload got=%h/%h/%h/%h want=0", awaddr, wdata, wstrb, araddr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_write_read();
        xact(1'b1, 4'd4, 32'hDEADBEEF, 4'hF, 1, 1, 2'b00, 0, 1'b0);
        checks++; if (obs_to !== 1'b0) begin failures++; $display("FAIL wr_timeout got=%b want=0", obs_to); end
        checks++; if (obs_pre !== 1'b0) begin failures++; $display("FAIL wr_valid_at_accept got=%b want=0", obs_pre); end
        checks++; if (obs_aw_first !== 1 || obs_w_first !== 1) begin failures++;
            $display("FAIL wr_valid_rise got=%0d/%0d want=1/1", obs_aw_first, obs_w_first); end
        checks++; if (obs_aw_fall !== 2 || obs_w_fall !== 2) begin failures++;
            $display("FAIL wr_valid_fall got=%0d/%0d want=2/2", obs_aw_fall, obs_w_fall); end
        checks++; if (obs_bready_k !== 2) begin failures++; $display("FAIL wr_bready_cycle got=%0d want=2", obs_bready_k); end
        checks++; if ({obs_awaddr, obs_wdata, obs_wstrb, obs_prot} !== {4'd4, 32'hDEADBEEF, 4'hF, 3'b000}) begin failures++;
            $display("FAIL wr_payload got=%h/%h/%h/%h want=4/deadbeef/f/0", obs_awaddr, obs_wdata, obs_wstrb, obs_prot); end
        checks++; if ({obs_rsp_write, obs_rsp_resp, obs_rsp_rdata} !== {1'b1, 2'b00, 32'h0}) begin failures++;
            $display("FAIL wr_rsp got=%b/%h/%h want=1/0/0", obs_rsp_write, obs_rsp_resp, obs_rsp_rdata); end
        xact(1'b0, 4'd4, 32'h0, 4'h0, 1, 1, 2'b00, 0, 1'b0);
        checks++; if (obs_ar_first !== 1 || obs_araddr !== 4'd4) begin failures++;
            $display("FAIL rd_ar got=%0d/%h want=1/4", obs_ar_first, obs_araddr); end
        checks++; if ({obs_rsp_write, obs_rsp_resp, obs_rsp_rdata} !== {1'b0, 2'b00, 32'hDEADBEEF}) begin failures++;
            $display("FAIL rd_rsp got=%b/%h/%h want=0/0/deadbeef", obs_rsp_write, obs_rsp_resp, obs_rsp_rdata); end
    endtask

    task automatic test_aw_before_w();
        xact(1'b1, 4'd8, 32'h12345678, 4'h3, 1, 4, 2'b00, 0, 1'b0);
        checks++; if (obs_aw_fall !== 2) begin failures++; $display("FAIL split_aw_fall got=%0d want=2", obs_aw_fall); end
        checks++; if (obs_w_fall !== 5) begin failures++; $display("FAIL split_w_fall got=%0d want=5", obs_w_fall); end
        checks++; if (obs_bready_k !== 5) begin failures++; $display("FAIL split_bready_cycle got=%0d want=5", obs_bready_k); end
        checks++; if (obs_reraise !== 1'b0 || obs_b_early !== 1'b0) begin failures++;
            $display("FAIL split_reraise got=%b/%b want=0/0", obs_reraise, obs_b_early); end
        xact(1'b0, 4'd8, 32'h0, 4'h0, 1, 1, 2'b00, 0, 1'b0);
        checks++; if (obs_rsp_rdata !== 32'h00005678) begin failures++;
            $display("FAIL split_readback got=%h want=00005678", obs_rsp_rdata); end
    endtask

    task automatic test_rsp_backpressure();
        xact(1'b0, 4'd4, 32'h0, 4'h0, 1, 1, 2'b00, 5, 1'b0);
        checks++; if (obs_to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b want=0", obs_to); end
        checks++; if (obs_unstable !== 1'b0) begin failures++; $display("FAIL bp_stable got=%b want=0", obs_unstable); end
        checks++; if (obs_rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_rdata got=%h want=deadbeef", obs_rsp_rdata); end
        checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready_busy got=%b want=0", obs_busy); end
        checks++; if (obs_ready_after !== 1'b1) begin failures++; $display("FAIL bp_cmd_ready_after got=%b want=1", obs_ready_after); end
    endtask

    task automatic test_errors();
        xact(1'b1, 4'd0, 32'h00000055, 4'hF, 1, 1, 2'b10, 0, 1'b0);
        checks++; if ({obs_rsp_write, obs_rsp_resp, obs_rsp_rdata} !== {1'b1, 2'b10, 32'h0}) begin failures++;
            $display("FAIL err_bresp got=%b/%h/%h want=1/2/0", obs_rsp_write, obs_rsp_resp, obs_rsp_rdata); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL err_count1 got=%0d want=1", err_count); end
        xact(1'b0, 4'd0, 32'h0, 4'h0, 1, 1, 2'b11, 0, 1'b0);
        checks++; if ({obs_rsp_write, obs_rsp_resp, obs_rsp_rdata} !== {1'b0, 2'b11, 32'h55}) begin failures++;
            $display("FAIL err_rresp got=%b/%h/%h want=0/3/55", obs_rsp_write, obs_rsp_resp, obs_rsp_rdata); end
        checks++; if (err_count !== 16'd2 || err_count2 !== 2'd2) begin failures++;
            $display("FAIL err_count2 got=%0d/%0d want=2/2", err_count, err_count2); end
        for (int i = 0; i < 3; i++) xact(1'b0, 4'd0, 32'h0, 4'h0, 1, 1, 2'b10, 0, 1'b0);
        checks++; if (err_count !== 16'd5) begin failures++; $display("FAIL err_count5 got=%0d want=5", err_count); end
        checks++; if (err_count2 !== 2'd3) begin failures++; $display("FAIL err_saturate got=%0d want=3", err_count2); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        cmd_write = 1'b1; cmd_addr = 4'd12; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        awready = 0; wready = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL mid_in_wr_req got=%b want=11", {awvalid, wvalid}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin failures++;
            $display("FAIL mid_valids got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
        checks++; if (err_count !== 16'd0 || err_count2 !== 2'd0) begin failures++;
            $display("FAIL mid_err got=%0d/%0d want=0/0", err_count, err_count2); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_in_reset got=%b want=0", cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b want=1", cmd_ready); end
        seen = 0;
        repeat (4) begin if (rsp_valid || awvalid || wvalid) seen = 1; @(negedge clk); end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got=%b want=0", seen); end
    endtask

    task automatic test_back_to_back();
        xact(1'b1, 4'd12, 32'hA5A5A5A5, 4'hF, 1, 2, 2'b00, 0, 1'b1);
        checks++; if (obs_overlap !== 1'b0 || obs_busy !== 1'b0 || obs_to !== 1'b0) begin failures++;
            $display("FAIL b2b_wr1 got=%b/%b/%b want=0/0/0", obs_overlap, obs_busy, obs_to); end
        xact(1'b0, 4'd12, 32'h0, 4'h0, 2, 1, 2'b00, 0, 1'b1);
        checks++; if (obs_rsp_rdata !== 32'hA5A5A5A5 || obs_overlap !== 1'b0 || obs_pre !== 1'b0) begin failures++;
            $display("FAIL b2b_rd1 got=%h/%b/%b want=a5a5a5a5/0/0", obs_rsp_rdata, obs_overlap, obs_pre); end
        xact(1'b1, 4'd0, 32'h000000C3, 4'hF, 1, 1, 2'b00, 0, 1'b1);
        checks++; if ({obs_rsp_write, obs_awaddr, obs_wdata} !== {1'b1, 4'd0, 32'hC3} || obs_overlap !== 1'b0) begin failures++;
            $display("FAIL b2b_wr2 got=%b/%h/%h/%b want=1/0/c3/0", obs_rsp_write, obs_awaddr, obs_wdata, obs_overlap); end
        xact(1'b0, 4'd0, 32'h0, 4'h0, 1, 1, 2'b00, 0, 1'b0);
        checks++; if (obs_rsp_rdata !== 32'h000000C3 || obs_rsp_write !== 1'b0) begin failures++;
            $display("FAIL b2b_rd2 got=%h/%b want=c3/0", obs_rsp_rdata, obs_rsp_write); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_aw_before_w();
        test_rsp_backpressure();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_manager.md
Name: axil_manager

Overview:
- Single-outstanding AXI4-Lite manager that sits directly upstream of the four-register AXI-Lite subordinate and drives its AW/W/B/AR/R channels.
- Converts a simple valid/ready command stream (read or write, address, data, strobes) into one AXI-Lite transaction at a time.
- Returns the result on a valid/ready response stream and keeps a saturating error counter.

Parameters:
- DATA_WIDTH, 32, width of the data bus; must be a multiple of 8.
- ADDRESS_WIDTH, 4, width of the byte address.
- ERR_COUNT_WIDTH, 16, width of the non-OKAY response counter.

Ports:
- axi_aclk_in  in  1  clock; all logic is on the rising edge.
- axi_areset_in  in  1  synchronous, active-high reset.
- cmd_valid_in  in  1  command valid.
- cmd_ready_out  out  1  command ready.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_addr_in  in  ADDRESS_WIDTH  byte address.
- cmd_wdata_in  in  DATA_WIDTH  write data.
- cmd_wstrb_in  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid_out  out  1  response valid.
- rsp_ready_in  in  1  response ready.
- rsp_write_out  out  1  response belongs to a write.
- rsp_rdata_out  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp_out  out  2  captured BRESP or RRESP.
- err_count_out  out  ERR_COUNT_WIDTH  count of non-OKAY responses.
- axi_awaddr_out  out  ADDRESS_WIDTH; axi_awprot_out  out  3; axi_awvalid_out  out  1; axi_awready_in  in  1.
- axi_wdata_out  out  DATA_WIDTH; axi_wstrb_out  out  DATA_WIDTH/8; axi_wvalid_out  out  1; axi_wready_in  in  1.
- axi_bresp_in  in  2; axi_bvalid_in  in  1; axi_bready_out  out  1.
- axi_araddr_out  out  ADDRESS_WIDTH; axi_arprot_out  out  3; axi_arvalid_out  out  1; axi_arready_in  in  1.
- axi_rdata_in  in  DATA_WIDTH; axi_rresp_in  in  2; axi_rvalid_in  in  1; axi_rready_out  out  1.

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- Reset, checked on a clock edge with axi_areset_in=1:
  - State goes to IDLE.
  - All AXI valid/ready outputs go to 0, and rsp_valid_out goes to 0.
  - err_count_out, rsp_* data and all AXI payload registers go to 0.
  - cmd_ready_out is 0 while axi_areset_in=1.
- Reset mid-transaction: the transaction is abandoned with no response, and the block is in IDLE on the next cycle.
- cmd_ready_out = (state==IDLE) && !axi_areset_in. This is combinational from state, with no dependence on cmd_valid_in.
- Command accept (IDLE, cmd_valid_in && cmd_ready_out):
  - Latch address, data and strobes into registers.
  - Write goes to WR_REQ, with axi_awvalid_out=1 and axi_wvalid_out=1 from the next cycle.
  - Read goes to RD_REQ, with axi_arvalid_out=1 from the next cycle.
  - AXI valid is therefore first visible one cycle after command acceptance.
- axi_awprot_out and axi_arprot_out are always 3'b000.
- Payload stability: AXI payload outputs are registered and do not change while the matching valid is high.
- WR_REQ:
  - AW and W complete independently.
  - axi_awvalid_out drops the cycle after (awvalid && awready); axi_wvalid_out drops the cycle after (wvalid && wready).
  - A per-channel "done" flag is set on each handshake.
  - When both channels are done, including both completing on the same edge, go to WR_RESP. Never re-raise a completed channel.
- WR_RESP:
  - axi_bready_out=1 in this state only.
  - On axi_bvalid_in && bready: capture bresp, set rsp_write_out=1 and rsp_rdata_out=0, go to RSP.
  - B is never accepted outside WR_RESP.
- RD_REQ: axi_arvalid_out=1 until arready, then go to RD_RESP.
- RD_RESP:
  - axi_rready_out=1 in this state only.
  - On rvalid && rready: capture rdata and rresp, set rsp_write_out=0, go to RSP.
- RSP:
  - rsp_valid_out=1, with response payload held stable until rsp_ready_in.
  - On handshake go to IDLE. The next command can be accepted on the following cycle.
  - No command is accepted in RSP.
- Error counter: increments once per captured response with resp != 2'b00, and saturates at all-ones.
- Only one transaction is outstanding at a time. Reads and writes never overlap.

Test Plan:
- Reset, then write addr=4, wdata=32'hDEADBEEF, wstrb=4'hF, with subordinate-style AW/W ready together:
  - awvalid and wvalid rise 1 cycle after accept and fall together.
  - bready is asserted; response has rsp_write_out=1, rsp_resp_out=0.
  - A following read of addr=4 returns rsp_rdata_out=32'hDEADBEEF.
- Write with awready asserted 3 cycles before wready:
  - awvalid falls after its handshake while wvalid stays high.
  - WR_RESP is entered only after W completes; awvalid is not re-raised.
- Read with rsp_ready_in held low for 5 cycles after rvalid:
  - rsp_valid_out and rsp_rdata_out stay stable.
  - cmd_ready_out stays 0 until the rsp handshake, and is 1 the cycle after.
- BRESP=2'b10 on one write and RRESP=2'b11 on one read:
  - err_count_out=2, and responses carry those codes.
  - With ERR_COUNT_WIDTH=2, 5 errors leave err_count_out=3.
- axi_areset_in asserted while in WR_REQ with wvalid=1:
  - All valids are 0 the next cycle, no rsp_valid_out is produced, err_count_out=0.
  - cmd_ready_out=1 once reset is released.
- Back-to-back commands with cmd_valid_in held high: exactly one AXI transaction is outstanding at any time, and commands complete in order.
